sm3_expnd_core: RTL and testbench
=================================

// Module: sm3_expnd_core
// PURPOSE
//   SM3 message-expansion stage, directly downstream of sm3_pad_core. Accepts the padded
//   message as 32-bit big-endian words, 16 per 512-bit block, and emits the 64 round
//   word pairs (W_j, W'_j), one pair per handshake, to the compression core.
//   Flow control toward the pad core uses its pad_otpt_ena_i. Downstream flow control is a
//   valid/ready handshake.
// PARAMETERS
//   WORD_DW    32   word width; 32 is the only legal value (fixed by SM3)
//   BLK_WORDS  16   words per block; fixed
//   ROUND_NUM  64   rounds per block; fixed
// PORTS
//   clk               in   1   clock, rising edge
//   rst_n             in   1   asynchronous reset, active low
//   pad_inpt_d_i      in   32  padded message word, big-endian
//   pad_inpt_vld_i    in   1   pad_inpt_d_i valid
//   pad_inpt_lst_i    in   1   with word 15: this block is the message's final block
//   expnd_inpt_rdy_o  out  1   ready for a word; drives sm3_pad_core.pad_otpt_ena_i
//   expnd_otpt_wj_o   out  32  W_j
//   expnd_otpt_wjj_o  out  32  W'_j = W_j ^ W_(j+4)
//   expnd_otpt_idx_o  out  6   round index j, 0..63
//   expnd_otpt_vld_o  out  1   round pair valid
//   expnd_otpt_lst_o  out  1   with j=63 of the final block
//   cmprss_rdy_i      in   1   compression core accepts the current pair
// BEHAVIOUR
//   Reset: all outputs 0, except expnd_inpt_rdy_o = 1 one cycle after deassertion.
//     Reset also clears the state to IDLE, the word/round counters, the window and the
//     lst latch. Reset mid-block discards all partial data.
//   FSM:
//     IDLE -> LOAD on the first accepted word.
//     LOAD -> EXPD after word 15 is accepted.
//     EXPD -> LOAD after the j=63 handshake when the block is not final.
//     EXPD -> IDLE after the j=63 handshake when the block is final.
//     IDLE and LOAD behave identically for input and may be merged.
//   Input handshake:
//     A word is accepted when pad_inpt_vld_i & expnd_inpt_rdy_o.
//     expnd_inpt_rdy_o = 1 in IDLE/LOAD and 0 in EXPD (registered, state-derived).
//   LOAD: window register w[0..15] is filled in order. Word k goes to w[k];
//     the 4-bit word counter runs 0..15.
//   pad_inpt_lst_i:
//     Sampled only with word 15 and latched as blk_lst.
//     On words 0..14 it is ignored.
//   EXPD outputs (registered sources, XOR only; no comb path from any input):
//     expnd_otpt_vld_o = 1
//     wj = w[0]
//     wjj = w[0]^w[4]
//     idx = round counter
//     expnd_otpt_lst_o = blk_lst & (idx==63)
//   Advance: only on expnd_otpt_vld_o & cmprss_rdy_i.
//     w[i] <= w[i+1] for i = 0..14.
//     w[15] <= P1(w[0]^w[7]^(w[13]<<<15)) ^ (w[3]<<<7) ^ w[10].
//     P1(x) = x ^ (x<<<15) ^ (x<<<23); <<< is a 32-bit rotate; all XOR, no carries.
//     The window always holds W_j..W_(j+15), so W'_63 (needs W_67) is always available.
//     Words beyond W_67 are computed but never used.
//   Without a handshake, all outputs hold stable (no change while vld=1 & rdy=0).
//   Latency: the first pair is valid the cycle after word 15 is accepted.
//     Best-case throughput is 80 cycles/block (16 load + 64 rounds).
//   After the j=63 handshake, vld/lst drop to 0 in the next cycle, together with
//     rdy_o returning to 1. The round counter wraps to 0.
//   Words presented while rdy_o=0 are not consumed. The pad core must hold them,
//     which it does because ena is low.
// TESTING
//   1) Reset with vld high and inputs random -> rdy_o=1, vld_o=0, no word consumed during reset.
//   2) GB/T 32905 "abc" block (61626380, 14x00000000, 00000018), lst with word 15:
//      -> idx0 wj=61626380, wjj=61626380
//      -> W16..W19 = 9092e200, 00000000, 000c0606, 719c70ed
//      -> lst_o only at idx 63, then IDLE.
//   3) Two-block message (standard 512-bit example), lst only on the 2nd block's word 15:
//      -> 128 pairs, lst_o once, rdy_o low exactly during both EXPD phases.
//   4) cmprss_rdy_i random 50% -> same W/W' sequence as test 2, outputs stable while stalled.
//   5) pad_inpt_vld_i gaps during LOAD plus lst pulsed on word 7 -> lst ignored,
//      block still starts after 16 words.
//   6) Assert rst_n at idx 30, then resend the "abc" block -> output identical to test 2.

Source files
------------

// File: rtl/sm3_expnd_if.sv
// Bundle of the SM3 expansion stage signals: the padded-word input stream from
// the pad core and the round-pair output stream toward the compression core.
//
// Handshakes:
//   Input  : a word transfers on a rising clk edge where pad_inpt_vld_i and
//            expnd_inpt_rdy_o are both 1. expnd_inpt_rdy_o is registered and
//            does not depend on pad_inpt_vld_i.
//   Output : a round pair transfers on a rising clk edge where
//            expnd_otpt_vld_o and cmprss_rdy_i are both 1. While vld is high
//            and rdy is low, every expnd_otpt_* signal holds its value.
interface sm3_expnd_if #(
   parameter int WORD_DW = 32
);
   logic [WORD_DW-1:0] pad_inpt_d_i;
   logic               pad_inpt_vld_i;
   logic               pad_inpt_lst_i;
   logic               expnd_inpt_rdy_o;
   logic [WORD_DW-1:0] expnd_otpt_wj_o;
   logic [WORD_DW-1:0] expnd_otpt_wjj_o;
   logic [5:0]         expnd_otpt_idx_o;
   logic               expnd_otpt_vld_o;
   logic               expnd_otpt_lst_o;
   logic               cmprss_rdy_i;

   // Expansion core side.
   modport slave (
      input  pad_inpt_d_i, pad_inpt_vld_i, pad_inpt_lst_i, cmprss_rdy_i,
      output expnd_inpt_rdy_o, expnd_otpt_wj_o, expnd_otpt_wjj_o,
             expnd_otpt_idx_o, expnd_otpt_vld_o, expnd_otpt_lst_o
   );

   // Environment side: drives words from the pad core, consumes round pairs.
   modport master (
      output pad_inpt_d_i, pad_inpt_vld_i, pad_inpt_lst_i, cmprss_rdy_i,
      input  expnd_inpt_rdy_o, expnd_otpt_wj_o, expnd_otpt_wjj_o,
             expnd_otpt_idx_o, expnd_otpt_vld_o, expnd_otpt_lst_o
   );
endinterface

// File: rtl/sm3_expnd_core.sv
// SM3 message expansion. Loads 16 big-endian words of a padded block into a
// sliding 16-word window, then emits (W_j, W_j ^ W_j+4) for j = 0..63, shifting
// the window by one word and appending the next expanded word per handshake.
// The window always holds W_j..W_j+15, so W'_63 (needing W_67) is available.
// All outputs come from registers through XOR/mux only; no input reaches an
// output combinationally. dbg_state exposes the FSM state.
module sm3_expnd_core #(
   parameter int WORD_DW   = 32,
   parameter int BLK_WORDS = 16,
   parameter int ROUND_NUM = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   sm3_expnd_if.slave       bus,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EXPD = 2'd2
   } state_t;

   localparam logic [3:0] LAST_WORD = 4'(BLK_WORDS - 1);
   localparam logic [5:0] LAST_RND  = 6'(ROUND_NUM - 1);

   state_t             state_q, state_d;
   logic [3:0]         wcnt_q;
   logic [5:0]         rcnt_q;
   logic               blk_lst_q;
   logic               rdy_q;
   logic [WORD_DW-1:0] w_q [BLK_WORDS];

   logic               expd;
   logic               in_acc;
   logic               out_acc;
   logic               last_word;
   logic               last_rnd;
   logic [WORD_DW-1:0] w_new;

   function automatic logic [WORD_DW-1:0] rol(input logic [WORD_DW-1:0] x, input int n);
      return (x << n) | (x >> (WORD_DW - n));
   endfunction

   function automatic logic [WORD_DW-1:0] p1(input logic [WORD_DW-1:0] x);
      return x ^ rol(x, 15) ^ rol(x, 23);
   endfunction

   assign expd      = (state_q == ST_EXPD);
   assign in_acc    = bus.pad_inpt_vld_i & rdy_q;
   assign out_acc   = expd & bus.cmprss_rdy_i;
   assign last_word = (wcnt_q == LAST_WORD);
   assign last_rnd  = (rcnt_q == LAST_RND);

   // W_j+16 from the current window W_j..W_j+15.
   assign w_new = p1(w_q[0] ^ w_q[7] ^ rol(w_q[13], 15)) ^ rol(w_q[3], 7) ^ w_q[10];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: load 16 words, expand 64 rounds, then back to idle or the next load.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_LOAD: begin
            if (in_acc) state_d = last_word ? ST_EXPD : ST_LOAD;
         end
         ST_EXPD: begin
            if (out_acc && last_rnd) state_d = blk_lst_q ? ST_IDLE : ST_LOAD;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Window, counters, final-block latch and the registered input ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q     <= 1'b0;
         wcnt_q    <= '0;
         rcnt_q    <= '0;
         blk_lst_q <= 1'b0;
         for (int i = 0; i < BLK_WORDS; i++) w_q[i] <= '0;
      end else begin
         // Ready is a function of the state being entered, so it drops on the
         // same edge that accepts word 15 and returns with the j=63 handshake.
         rdy_q <= (state_d != ST_EXPD);
         if (in_acc) begin
            w_q[wcnt_q] <= bus.pad_inpt_d_i;
            wcnt_q      <= wcnt_q + 4'd1;
            if (last_word) blk_lst_q <= bus.pad_inpt_lst_i;
         end
         if (out_acc) begin
            for (int i = 0; i < BLK_WORDS - 1; i++) w_q[i] <= w_q[i+1];
            w_q[BLK_WORDS-1] <= w_new;
            rcnt_q           <= rcnt_q + 6'd1;
         end
      end
   end

   assign bus.expnd_inpt_rdy_o = rdy_q;
   assign bus.expnd_otpt_vld_o = expd;
   assign bus.expnd_otpt_wj_o  = expd ? w_q[0] : '0;
   assign bus.expnd_otpt_wjj_o = expd ? (w_q[0] ^ w_q[4]) : '0;
   assign bus.expnd_otpt_idx_o = rcnt_q;
   assign bus.expnd_otpt_lst_o = expd & blk_lst_q & last_rnd;
   assign dbg_state            = state_q;

endmodule

// File: tb/tb_sm3_expnd_core.sv
// Directed bench for sm3_expnd_core: GB/T 32905 "abc" block, the two-block
// 512-bit example, random downstream stalls, input gaps with a stray lst, and
// reset in the middle of expansion. Expected pairs come from a reference
// expansion of the loaded message; hand-derived constants anchor the "abc" run.
module tb_sm3_expnd_core;

   localparam int W = 71;  // {lst, idx[5:0], wj[31:0], wjj[31:0]}

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] dbg_state;

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   sm3_expnd_if bus ();

   sm3_expnd_core dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int           total = 0;
   int           bad = 0;
   int           lst_seen = 0;
   int           rdy_bad = 0;
   logic [W-1:0] exp_q[$];
   logic [31:0]  mw [68];
   logic [31:0]  obs_w [64];
   logic [31:0]  obs_wjj [64];

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Reference expansion model.
   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      logic [63:0] t;
      t = {x, x} << n;
      return t[63:32];
   endfunction

   function automatic logic [31:0] perm1(input logic [31:0] x);
      return x ^ rotl(x, 15) ^ rotl(x, 23);
   endfunction

   task automatic gen_expected(input bit final_blk);
      for (int n = 16; n < 68; n++)
         mw[n] = perm1(mw[n-16] ^ mw[n-9] ^ rotl(mw[n-3], 15)) ^ rotl(mw[n-13], 7) ^ mw[n-6];
      for (int j = 0; j < 64; j++)
         exp_q.push_back({(final_blk && j == 63), 6'(j), mw[j], mw[j] ^ mw[j+4]});
   endtask

   task automatic load_abc();
      for (int k = 0; k < 16; k++) mw[k] = 32'h0;
      mw[0]  = 32'h61626380;
      mw[15] = 32'h00000018;
   endtask

   task automatic load_two_a();
      for (int k = 0; k < 16; k++) mw[k] = 32'h61626364;
   endtask

   task automatic load_two_b();
      for (int k = 0; k < 16; k++) mw[k] = 32'h0;
      mw[0]  = 32'h80000000;
      mw[15] = 32'h00000200;
   endtask

   // Driver: present one word and hold it until the DUT takes it.
   task automatic send_word(input logic [31:0] d, input logic l);
      int guard;
      guard = 0;
      bus.pad_inpt_d_i   = d;
      bus.pad_inpt_vld_i = 1'b1;
      bus.pad_inpt_lst_i = l;
      while (!bus.expnd_inpt_rdy_o && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check("send_timeout", W'(guard < 200), W'(1));
      @(posedge clk); #1;
      bus.pad_inpt_vld_i = 1'b0;
      bus.pad_inpt_lst_i = 1'b0;
      bus.pad_inpt_d_i   = $urandom;
   endtask

   // Driver: send mw[0..15]; lst_mask[k] drives lst with word k.
   task automatic send_block(input bit gaps, input logic [15:0] lst_mask);
      for (int k = 0; k < 16; k++) begin
         send_word(mw[k], lst_mask[k]);
         if (gaps && k < 15) begin
            repeat ($urandom_range(0, 3)) begin
               bus.pad_inpt_d_i = $urandom;
               bus.pad_inpt_lst_i = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            bus.pad_inpt_lst_i = 1'b0;
         end
      end
      // First pair is valid the cycle after word 15 is taken.
      check("first_vld", W'(bus.expnd_otpt_vld_o), W'(1));
      check("rdy_drop",  W'(bus.expnd_inpt_rdy_o), W'(0));
      check("first_idx", W'(bus.expnd_otpt_idx_o), W'(0));
   endtask

   // Scoreboard consumer: pops exp_q per handshake, checks holds while stalled.
   task automatic recv_block(input bit rnd, input int stop_idx);
      int           guard;
      bit           stalled;
      bit           quit;
      bit           crdy;
      logic [W-1:0] cur;
      logic [W-1:0] held;
      logic [W-1:0] e;
      guard = 0; stalled = 0; quit = 0; held = '0;
      while (exp_q.size() > 0 && !quit && guard < 3000) begin
         crdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.expnd_otpt_vld_o) begin
            cur = {bus.expnd_otpt_lst_o, bus.expnd_otpt_idx_o,
                   bus.expnd_otpt_wj_o, bus.expnd_otpt_wjj_o};
            if (stalled) check("stall_hold", cur, held);
            if (bus.expnd_inpt_rdy_o) rdy_bad++;
            if (stop_idx >= 0 && int'(bus.expnd_otpt_idx_o) == stop_idx) begin
               quit = 1;
               crdy = 1'b0;
            end else if (crdy) begin
               e = exp_q.pop_front();
               check("pair", cur, e);
               obs_w[bus.expnd_otpt_idx_o]   = bus.expnd_otpt_wj_o;
               obs_wjj[bus.expnd_otpt_idx_o] = bus.expnd_otpt_wjj_o;
               if (bus.expnd_otpt_lst_o) lst_seen++;
               stalled = 0;
            end else begin
               stalled = 1;
               held = cur;
            end
         end
         bus.cmprss_rdy_i = crdy;
         if (!quit) begin
            @(posedge clk); #1;
            guard++;
         end
      end
      bus.cmprss_rdy_i = 1'b0;
      check("recv_timeout", W'(guard < 3000), W'(1));
   endtask

   // Cycle after the final handshake: outputs quiet, ready back, FSM in st.
   task automatic check_after(input logic [1:0] st);
      check("after_vld",   W'(bus.expnd_otpt_vld_o), W'(0));
      check("after_lst",   W'(bus.expnd_otpt_lst_o), W'(0));
      check("after_rdy",   W'(bus.expnd_inpt_rdy_o), W'(1));
      check("after_idx",   W'(bus.expnd_otpt_idx_o), W'(0));
      check("after_state", W'(dbg_state), W'(st));
   endtask

   task automatic check_reset_outputs();
      check("rst_rdy",   W'(bus.expnd_inpt_rdy_o), W'(0));
      check("rst_vld",   W'(bus.expnd_otpt_vld_o), W'(0));
      check("rst_lst",   W'(bus.expnd_otpt_lst_o), W'(0));
      check("rst_wj",    W'(bus.expnd_otpt_wj_o),  W'(0));
      check("rst_wjj",   W'(bus.expnd_otpt_wjj_o), W'(0));
      check("rst_idx",   W'(bus.expnd_otpt_idx_o), W'(0));
      check("rst_state", W'(dbg_state), W'(0));
   endtask

   // Directed sequence.
   initial begin
      // 1) reset with input valid high and random data
      bus.pad_inpt_d_i   = $urandom;
      bus.pad_inpt_vld_i = 1'b1;
      bus.pad_inpt_lst_i = 1'b1;
      bus.cmprss_rdy_i   = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_rdy",   W'(bus.expnd_inpt_rdy_o), W'(1));
      check("post_rst_state", W'(dbg_state), W'(0));
      check("post_rst_vld",   W'(bus.expnd_otpt_vld_o), W'(0));
      bus.pad_inpt_vld_i = 1'b0;
      bus.pad_inpt_lst_i = 1'b0;
      bus.cmprss_rdy_i   = 1'b0;
      @(posedge clk); #1;

      // 2) "abc" single final block
      lst_seen = 0; rdy_bad = 0;
      load_abc();
      gen_expected(1'b1);
      send_block(1'b0, 16'h8000);
      recv_block(1'b0, -1);
      check_after(2'd0);
      check("abc_w0",    W'(obs_w[0]),    W'(32'h61626380));
      check("abc_wjj0",  W'(obs_wjj[0]),  W'(32'h61626380));
      check("abc_w16",   W'(obs_w[16]),   W'(32'h9092e200));
      check("abc_w17",   W'(obs_w[17]),   W'(32'h00000000));
      check("abc_w18",   W'(obs_w[18]),   W'(32'h000c0606));
      check("abc_w19",   W'(obs_w[19]),   W'(32'h719c70ed));
      check("abc_wjj12", W'(obs_wjj[12]), W'(32'h9092e200));
      check("abc_wjj15", W'(obs_wjj[15]), W'(32'h719c70f5));
      check("abc_lst_cnt", W'(lst_seen), W'(1));
      check("abc_rdy_in_expd", W'(rdy_bad), W'(0));

      // 3) two-block message, lst only with word 15 of block 2
      lst_seen = 0; rdy_bad = 0;
      load_two_a();
      gen_expected(1'b0);
      send_block(1'b0, 16'h0000);
      recv_block(1'b0, -1);
      check_after(2'd1);
      load_two_b();
      gen_expected(1'b1);
      send_block(1'b0, 16'h8000);
      recv_block(1'b0, -1);
      check_after(2'd0);
      check("two_lst_cnt", W'(lst_seen), W'(1));
      check("two_rdy_in_expd", W'(rdy_bad), W'(0));

      // 4) "abc" with random downstream stalls
      lst_seen = 0; rdy_bad = 0;
      load_abc();
      gen_expected(1'b1);
      send_block(1'b0, 16'h8000);
      recv_block(1'b1, -1);
      check_after(2'd0);
      check("stall_lst_cnt", W'(lst_seen), W'(1));
      check("stall_w19", W'(obs_w[19]), W'(32'h719c70ed));

      // 5) input gaps, lst pulsed on word 7 only: block is not final
      lst_seen = 0; rdy_bad = 0;
      load_abc();
      gen_expected(1'b0);
      send_block(1'b1, 16'h0080);
      recv_block(1'b0, -1);
      check_after(2'd1);
      check("gap_lst_cnt", W'(lst_seen), W'(0));

      // 6) reset at idx 30, then resend "abc"
      load_abc();
      gen_expected(1'b1);
      send_block(1'b0, 16'h8000);
      recv_block(1'b0, 30);
      check("abort_idx", W'(bus.expnd_otpt_idx_o), W'(30));
      exp_q.delete();
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_after(2'd0);
      lst_seen = 0; rdy_bad = 0;
      load_abc();
      gen_expected(1'b1);
      send_block(1'b0, 16'h8000);
      recv_block(1'b0, -1);
      check_after(2'd0);
      check("rerun_w16", W'(obs_w[16]), W'(32'h9092e200));
      check("rerun_lst_cnt", W'(lst_seen), W'(1));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
